sl_transmitter: RTL



---
 rtl/sl_pkg.sv | 36 +++
 rtl/sl_phase_timer.sv | 30 +++
 rtl/sl_transmitter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sl_pkg.sv
// sl_pkg: definitions shared by the SL transmitter and SL receiver.
//   - configuration field bit positions and the configuration reset value
//   - legal data bit count range
//   - transmitter FSM state encoding
//   - helpers to validate a bit count and mask a word down to it
package sl_pkg;

  localparam int CFG_PCE = 0;
  localparam int CFG_BQL = 1;
  localparam int CFG_BQH = 6;
  localparam int CFG_PEI = 9;

  localparam logic [15:0] CFG_RESET = 16'h0010;

  localparam int BQ_MIN = 8;
  localparam int BQ_MAX = 32;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_BIT_LOW,
    TX_BIT_HIGH,
    TX_STOP_LOW,
    TX_STOP_HIGH
  } tx_state_e;

  // Bit count must be even and within BQ_MIN..BQ_MAX.
  function automatic logic bq_valid(input logic [5:0] bq);
    return !bq[0] && (bq >= 6'(BQ_MIN)) && (bq <= 6'(BQ_MAX));
  endfunction

  // Mask with the low bq bits set; only called with legal bq values.
  function automatic logic [31:0] bq_mask(input logic [5:0] bq);
    return 32'hFFFF_FFFF >> (6'd32 - bq);
  endfunction

endpackage

// File: rtl/sl_phase_timer.sv
// sl_phase_timer: loadable down-counter timing one line phase.
//   clk, rst     : clock, asynchronous active-high reset
//   load_i       : load load_val_i into the counter this edge
//   load_val_i   : value to load (phase length minus one for a plain phase)
//   expired_o    : counter has reached zero
module sl_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/sl_transmitter.sv
// sl_transmitter: serial-line word transmitter on the zeroes/ones line pair.
// Sends BQ data bits LSB first, an odd-ones parity bit (optionally inverted
// by PEI), then a stop bit; every bit is followed by an idle-high gap.
//   clk, rst            : clock, asynchronous active-high reset
//   wr_config_w         : configuration value to write
//   wr_enable           : configuration write request (dropped unless idle and BQ legal)
//   tx_data_w           : word to send, bits at BQ and above ignored
//   tx_req              : send request, accepted when tx_ready is high
//   tx_ready            : idle and able to accept a word
//   tx_done             : one-cycle pulse at the end of a frame
//   serial_line_zeroes  : zeroes line, idle high
//   serial_line_ones    : ones line, idle high
//   r_config_w          : current configuration
//
// state        | meaning
// TX_IDLE      | lines high, waiting for a handshake
// TX_BIT_LOW   | data or parity bit: one line held low
// TX_BIT_HIGH  | both lines high after a bit
// TX_STOP_LOW  | stop bit: both lines low
// TX_STOP_HIGH | both lines high after the stop bit, then done
module sl_transmitter
  import sl_pkg::*;
#(
  parameter int LOW_CYCLES   = 8,
  parameter int HIGH_CYCLES  = 8,
  parameter int CONFIG_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CONFIG_WIDTH-1:0] wr_config_w,
  input  logic                    wr_enable,
  input  logic [31:0]             tx_data_w,
  input  logic                    tx_req,
  output logic                    tx_ready,
  output logic                    tx_done,
  output logic                    serial_line_zeroes,
  output logic                    serial_line_ones,
  output logic [CONFIG_WIDTH-1:0] r_config_w
);

  localparam int PH_MAX = (LOW_CYCLES > HIGH_CYCLES) ? LOW_CYCLES : HIGH_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  tx_state_e             state_q;
  logic [CONFIG_WIDTH-1:0] cfg_q;
  logic [5:0]            bq_q;
  logic                  par_q;
  logic [31:0]           shreg_q;
  logic [5:0]            bit_cnt_q;
  logic                  zeroes_q;
  logic                  ones_q;
  logic                  ready_q;
  logic                  done_q;

  logic                  hs;
  logic                  cur_bit;
  logic                  nxt_bit;
  logic                  tm_load;
  logic [PH_W-1:0]       tm_val;
  logic                  tm_exp;
  logic [5:0]            cfg_bq;
  logic [31:0]           data_masked;

  assign hs          = tx_req && ready_q;
  assign cfg_bq      = cfg_q[CFG_BQH:CFG_BQL];
  assign data_masked = tx_data_w & bq_mask(cfg_bq);

  // bit_cnt_q holds the index of the bit on the line (during BIT_LOW) or of
  // the next bit to send (during BIT_HIGH); index BQ is the parity bit.
  assign cur_bit = (bit_cnt_q == bq_q) ? par_q : shreg_q[0];
  assign nxt_bit = (bit_cnt_q == bq_q) ? par_q : shreg_q[1];

  // The first low phase is loaded with the full LOW_CYCLES because the line
  // drops one clock after the handshake; all later phases start on the same
  // edge their lines change, so they load length minus one.
  always_comb begin
    tm_load = 1'b0;
    tm_val  = '0;
    case (state_q)
      TX_IDLE: begin
        if (hs) begin
          tm_load = 1'b1;
          tm_val  = PH_W'(LOW_CYCLES);
        end
      end
      TX_BIT_LOW, TX_STOP_LOW: begin
        if (tm_exp) begin
          tm_load = 1'b1;
          tm_val  = PH_W'(HIGH_CYCLES - 1);
        end
      end
      TX_BIT_HIGH: begin
        if (tm_exp) begin
          tm_load = 1'b1;
          tm_val  = PH_W'(LOW_CYCLES - 1);
        end
      end
      default: ;
    endcase
  end

  sl_phase_timer #(.W(PH_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tm_load),
    .load_val_i (tm_val),
    .expired_o  (tm_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      cfg_q     <= CONFIG_WIDTH'(CFG_RESET);
      bq_q      <= 6'(BQ_MIN);
      par_q     <= 1'b0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      zeroes_q  <= 1'b1;
      ones_q    <= 1'b1;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if ((state_q == TX_IDLE) && wr_enable && bq_valid(wr_config_w[CFG_BQH:CFG_BQL])) begin
        cfg_q <= wr_config_w;
      end

      case (state_q)
        TX_IDLE: begin
          // Frame parameters come from the configuration held before any
          // write on this same edge.
          if (hs) begin
            state_q   <= TX_BIT_LOW;
            ready_q   <= 1'b0;
            bq_q      <= cfg_bq;
            shreg_q   <= data_masked;
            par_q     <= (~^data_masked) ^ cfg_q[CFG_PEI];
            bit_cnt_q <= '0;
          end
        end
        TX_BIT_LOW: begin
          if (tm_exp) begin
            state_q   <= TX_BIT_HIGH;
            zeroes_q  <= 1'b1;
            ones_q    <= 1'b1;
            bit_cnt_q <= bit_cnt_q + 6'd1;
          end else begin
            zeroes_q <= cur_bit;
            ones_q   <= ~cur_bit;
          end
        end
        TX_BIT_HIGH: begin
          if (tm_exp) begin
            if (bit_cnt_q == bq_q + 6'd1) begin
              state_q  <= TX_STOP_LOW;
              zeroes_q <= 1'b0;
              ones_q   <= 1'b0;
            end else begin
              state_q  <= TX_BIT_LOW;
              shreg_q  <= shreg_q >> 1;
              zeroes_q <= nxt_bit;
              ones_q   <= ~nxt_bit;
            end
          end
        end
        TX_STOP_LOW: begin
          if (tm_exp) begin
            state_q  <= TX_STOP_HIGH;
            zeroes_q <= 1'b1;
            ones_q   <= 1'b1;
          end
        end
        TX_STOP_HIGH: begin
          if (tm_exp) begin
            state_q <= TX_IDLE;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign tx_ready           = ready_q;
  assign tx_done            = done_q;
  assign serial_line_zeroes = zeroes_q;
  assign serial_line_ones   = ones_q;
  assign r_config_w         = cfg_q;

endmodule
